// File: rtl/gpio_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gpio_controller : memory-mapped multi-channel GPIO with edge interrupts    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module gpio_controller #(
   parameter int                    DATA_WIDTH   = 32,
   parameter int                    GPIO_WIDTH   = 8,
   parameter int                    NUM_CHANNELS = 2,
   parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = 32'h10010100
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [DATA_WIDTH-1:0]              Address_i,
   input  logic                               Write_Enable_i,
   input  logic [DATA_WIDTH-1:0]              Write_Data_i,
   output logic [DATA_WIDTH-1:0]              Read_Data_o,
   input  logic [NUM_CHANNELS*GPIO_WIDTH-1:0] GPIO_i,
   output logic [NUM_CHANNELS*GPIO_WIDTH-1:0] GPIO_o,
   output logic [NUM_CHANNELS*GPIO_WIDTH-1:0] GPIO_oe,
   output logic                               Irq_o
);

   localparam int                    c_NW   = NUM_CHANNELS * GPIO_WIDTH;
   localparam logic [DATA_WIDTH-1:0] c_SPAN = DATA_WIDTH'(NUM_CHANNELS * 32);

   localparam logic [2:0] c_REG_OUT    = 3'd0;
   localparam logic [2:0] c_REG_DIR    = 3'd1;
   localparam logic [2:0] c_REG_IN     = 3'd2;
   localparam logic [2:0] c_REG_STATUS = 3'd3;
   localparam logic [2:0] c_REG_IRQ_EN = 3'd4;

   logic [DATA_WIDTH-1:0] w_offset;
   logic                  w_in_range;
   logic [2:0]            w_chan;
   logic [2:0]            w_reg;
   logic [GPIO_WIDTH-1:0] w_wdata;
   logic                  w_unused_ok;

   assign w_offset    = Address_i - BASE_ADDRESS;
   assign w_in_range  = (w_offset < c_SPAN);
   assign w_chan      = w_offset[7:5];
   assign w_reg       = w_offset[4:2];
   assign w_wdata     = Write_Data_i[GPIO_WIDTH-1:0];
   assign w_unused_ok = ^{Write_Data_i, w_offset};

   logic [c_NW-1:0] r_s1;
   logic [c_NW-1:0] r_s2;
   logic [c_NW-1:0] r_s3;
   logic [1:0]      r_warm;
   logic            r_irq;

   logic [c_NW-1:0] w_out_all;
   logic [c_NW-1:0] w_dir_all;
   logic [c_NW-1:0] w_en_all;
   logic [c_NW-1:0] w_st_all;
   logic [c_NW-1:0] w_rise;
   logic            w_warm_done;

   // Rising edges only count on input pins once the synchroniser has flushed.
   assign w_warm_done = (r_warm == 2'd3);
   assign w_rise      = r_s2 & ~r_s3 & ~w_dir_all & {c_NW{w_warm_done}};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1   <= '0;
         r_s2   <= '0;
         r_s3   <= '0;
         r_warm <= 2'd0;
         r_irq  <= 1'b0;
      end else begin
         r_s1  <= GPIO_i;
         r_s2  <= r_s1;
         r_s3  <= r_s2;
         r_irq <= |(w_st_all & w_en_all);
         if (!w_warm_done) begin
            r_warm <= r_warm + 2'd1;
         end
      end
   end

   for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
      logic [GPIO_WIDTH-1:0] r_out;
      logic [GPIO_WIDTH-1:0] r_dir;
      logic [GPIO_WIDTH-1:0] r_en;
      logic [GPIO_WIDTH-1:0] r_status;
      logic                  w_wr_ch;
      logic [GPIO_WIDTH-1:0] w_clr;

      assign w_wr_ch = Write_Enable_i && w_in_range && (w_chan == 3'(c));
      assign w_clr   = (w_wr_ch && (w_reg == c_REG_STATUS)) ? w_wdata : '0;

      always_ff @(posedge clk) begin
         if (reset) begin
            r_out    <= '0;
            r_dir    <= '0;
            r_en     <= '0;
            r_status <= '0;
         end else begin
            if (w_wr_ch && (w_reg == c_REG_OUT)) begin
               r_out <= w_wdata;
            end
            if (w_wr_ch && (w_reg == c_REG_DIR)) begin
               r_dir <= w_wdata;
            end
            if (w_wr_ch && (w_reg == c_REG_IRQ_EN)) begin
               r_en <= w_wdata;
            end
            // Set has priority over a simultaneous write-1-to-clear.
            r_status <= (r_status & ~w_clr) | w_rise[c*GPIO_WIDTH +: GPIO_WIDTH];
         end
      end

      assign w_out_all[c*GPIO_WIDTH +: GPIO_WIDTH] = r_out;
      assign w_dir_all[c*GPIO_WIDTH +: GPIO_WIDTH] = r_dir;
      assign w_en_all [c*GPIO_WIDTH +: GPIO_WIDTH] = r_en;
      assign w_st_all [c*GPIO_WIDTH +: GPIO_WIDTH] = r_status;
   end

   logic [GPIO_WIDTH-1:0] w_rd_sel;
   logic [DATA_WIDTH-1:0] w_rdata;

   always_comb begin
      w_rd_sel = '0;
      if (w_in_range) begin
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (w_chan == 3'(c)) begin
               case (w_reg)
                  c_REG_OUT:    w_rd_sel = w_out_all[c*GPIO_WIDTH +: GPIO_WIDTH];
                  c_REG_DIR:    w_rd_sel = w_dir_all[c*GPIO_WIDTH +: GPIO_WIDTH];
                  c_REG_IN:     w_rd_sel = r_s2[c*GPIO_WIDTH +: GPIO_WIDTH];
                  c_REG_STATUS: w_rd_sel = w_st_all[c*GPIO_WIDTH +: GPIO_WIDTH];
                  c_REG_IRQ_EN: w_rd_sel = w_en_all[c*GPIO_WIDTH +: GPIO_WIDTH];
                  default:      w_rd_sel = '0;
               endcase
            end
         end
      end
   end

   always_comb begin
      w_rdata                 = '0;
      w_rdata[GPIO_WIDTH-1:0] = w_rd_sel;
   end

   assign Read_Data_o = w_rdata;
   assign GPIO_o      = w_out_all;
   assign GPIO_oe     = w_dir_all;
   assign Irq_o       = r_irq;

endmodule
`default_nettype wire
